// File: rtl/simptel_pkg.sv
// Shared definitions for the Simptel-O9 memory subsystem.
//   ADDR_W    : word-address width used by fetch, load/store and RAM ports
//   DATA_W    : RAM data width
//   MEM_DEPTH : number of implemented RAM words
//   grant_e   : which requester owns the RAM in the current cycle
package simptel_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_DATA
    } grant_e;

    // True when a word address maps onto an implemented RAM word.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned        depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/arb_resp_reg.sv
// Per-port response register for ram_arbiter.
//   clock/reset : system clock, asynchronous active-high reset
//   accept_i    : request accepted at this edge
//   rdata_i     : data to capture on accept (already zeroed for store/fault)
//   fault_i     : accepted address was out of range
//   rvalid_o    : one-cycle response pulse following the accept
//   rdata_o     : captured data, held until the next accept
//   fault_o     : fault flag, pulses together with rvalid_o
module arb_resp_reg
    import simptel_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              accept_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              fault_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              fault_o
);

    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              fault_q,  fault_d;

    always_comb begin
        rvalid_d = accept_i;
        fault_d  = accept_i & fault_i;
        rdata_d  = accept_i ? rdata_i : rdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign fault_o  = fault_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port program/data RAM between instruction fetch and the
// load/store unit. Data wins contention unless fetch has lost STARVE_LIMIT
// consecutive contended cycles. Responses are registered one cycle after
// accept; out-of-range addresses are accepted but never written and return a
// fault with zero data.
//   clock, reset                    : system clock, async active-high reset
//   f_req/f_addr/f_ready            : fetch request handshake
//   f_rvalid/f_rdata/f_fault        : fetch response
//   d_req/d_we/d_addr/d_wdata/d_ready : load/store request handshake
//   d_rvalid/d_rdata/d_fault        : load/store response
//   mem_address/mem_data/mem_wren   : RAM command
//   mem_q                           : RAM combinational read data
module ram_arbiter
    import simptel_pkg::*;
#(
    parameter int unsigned DEPTH        = MEM_DEPTH,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_fault,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    grant_e            gnt;
    logic              f_oor, d_oor;
    logic [DATA_W-1:0] f_rdata_in, d_rdata_in;

    assign f_oor = !addr_in_range(f_addr, DEPTH);
    assign d_oor = !addr_in_range(d_addr, DEPTH);

    // Grant is suppressed while reset is high so no write can reach the RAM.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (d_req && !(f_req && (starve_cnt_q == StarveMax))) begin
                gnt = GNT_DATA;
            end else if (f_req) begin
                gnt = GNT_FETCH;
            end
        end
    end

    // Counts contended cycles lost by fetch; any other cycle clears it.
    always_comb begin
        starve_cnt_d = '0;
        if (f_req && (gnt == GNT_DATA)) begin
            starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        f_ready     = 1'b0;
        d_ready     = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        unique case (gnt)
            GNT_FETCH: begin
                f_ready     = 1'b1;
                mem_address = f_addr;
            end
            GNT_DATA: begin
                d_ready     = 1'b1;
                mem_address = d_addr;
                mem_data    = d_wdata;
                mem_wren    = d_we && !d_oor;
            end
            default: ;
        endcase
    end

    assign f_rdata_in = f_oor ? '0 : mem_q;
    assign d_rdata_in = (d_oor || d_we) ? '0 : mem_q;

    arb_resp_reg u_f_resp (
        .clock    (clock),
        .reset    (reset),
        .accept_i (f_ready),
        .rdata_i  (f_rdata_in),
        .fault_i  (f_oor),
        .rvalid_o (f_rvalid),
        .rdata_o  (f_rdata),
        .fault_o  (f_fault)
    );

    arb_resp_reg u_d_resp (
        .clock    (clock),
        .reset    (reset),
        .accept_i (d_ready),
        .rdata_i  (d_rdata_in),
        .fault_i  (d_oor),
        .rvalid_o (d_rvalid),
        .rdata_o  (d_rdata),
        .fault_o  (d_fault)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_ready, f_rvalid, f_fault;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready, d_rvalid, d_fault;
    logic [31:0] d_rdata;
    logic [15:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [1024];

    always #5 clock = ~clock;

    assign mem_q = ram[mem_address[9:0]];
    always @(posedge clock) if (mem_wren) ram[mem_address[9:0]] <= mem_data;

    ram_arbiter #(.DEPTH(1024), .STARVE_LIMIT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_ready     (f_ready),
        .f_rvalid    (f_rvalid),
        .f_rdata     (f_rdata),
        .f_fault     (f_fault),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .d_fault     (d_fault),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    function automatic logic [31:0] pre(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    task automatic test_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0001; d_wdata = 32'h5555_AAAA;
        f_req = 1'b1; f_addr = 16'h0002;
        repeat (2) @(negedge clock);
        checks++;
        if (f_ready !== 1'b0 || d_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got f=%b d=%b want 0 0", f_ready, d_ready);
        end
        checks++;
        if (mem_wren !== 1'b0) begin
            errors++; $display("FAIL reset_wren: got %b want 0", mem_wren);
        end
        checks++;
        if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_fault !== 1'b0 || d_fault !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b%b%b%b want 0000",
                               f_rvalid, d_rvalid, f_fault, d_fault);
        end
        checks++;
        if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h %h want 0 0", f_rdata, d_rdata);
        end
        checks++;
        if (ram[1] !== pre(1)) begin
            errors++; $display("FAIL reset_nowrite: got %h want %h", ram[1], pre(1));
        end
        d_req = 1'b0; d_we = 1'b0; f_req = 1'b0;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (d_ready !== 1'b1 || f_ready !== 1'b0 || mem_wren !== 1'b1 ||
            mem_address !== 16'h0010 || mem_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_cmd: got rdy=%b wren=%b addr=%h data=%h want 1 1 0010 deadbeef",
                               d_ready, mem_wren, mem_address, mem_data);
        end
        @(negedge clock);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_fault !== 1'b0) begin
            errors++; $display("FAIL store_resp: got v=%b d=%h f=%b want 1 0 0", d_rvalid, d_rdata, d_fault);
        end
        d_we = 1'b0;
        #1;
        checks++;
        if (d_ready !== 1'b1 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL load_cmd: got rdy=%b wren=%b want 1 0", d_ready, mem_wren);
        end
        @(negedge clock);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_resp: got v=%b d=%h want 1 deadbeef", d_rvalid, d_rdata);
        end
        d_req = 1'b0;
        #1;
        checks++;
        if (mem_address !== 16'h0 || mem_data !== 32'h0 || mem_wren !== 1'b0 || d_ready !== 1'b0) begin
            errors++; $display("FAIL idle_cmd: got addr=%h data=%h wren=%b rdy=%b want 0 0 0 0",
                               mem_address, mem_data, mem_wren, d_ready);
        end
        @(negedge clock);
        checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rdata_hold: got v=%b d=%h want 0 deadbeef", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_fetch_stream();
        for (int i = 0; i <= 11; i++) begin
            if (i > 0) begin
                checks++;
                if (f_rvalid !== 1'b1 || f_rdata !== pre(i - 1) || f_fault !== 1'b0) begin
                    errors++; $display("FAIL fetch_stream_resp[%0d]: got v=%b d=%h want 1 %h",
                                       i - 1, f_rvalid, f_rdata, pre(i - 1));
                end
            end
            if (i <= 10) begin
                f_req = 1'b1; f_addr = 16'(i);
                #1;
                checks++;
                if (f_ready !== 1'b1 || mem_address !== 16'(i) || mem_wren !== 1'b0) begin
                    errors++; $display("FAIL fetch_stream_rdy[%0d]: got rdy=%b addr=%h want 1 %h",
                                       i, f_ready, mem_address, 16'(i));
                end
            end else begin
                f_req = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    // Both requesters held: expected grant pattern D,D,D,D,F repeating.
    task automatic test_starvation();
        logic prev_f = 1'b0;
        f_req = 1'b1; f_addr = 16'h0005;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0007;
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) begin
                checks++;
                if (f_rvalid !== prev_f || d_rvalid !== !prev_f ||
                    (prev_f && f_rdata !== pre(5)) || (!prev_f && d_rdata !== pre(7))) begin
                    errors++; $display("FAIL starve_resp[%0d]: got fv=%b dv=%b fd=%h dd=%h want fv=%b",
                                       k, f_rvalid, d_rvalid, f_rdata, d_rdata, prev_f);
                end
            end
            if (k <= 10) begin
                #1;
                prev_f = ((k % 5) == 4);
                checks++;
                if (f_ready !== prev_f || d_ready !== !prev_f) begin
                    errors++; $display("FAIL starve_grant[%0d]: got f=%b d=%b want f=%b d=%b",
                                       k, f_ready, d_ready, prev_f, !prev_f);
                end
                @(negedge clock);
            end else begin
                f_req = 1'b0; d_req = 1'b0;
                @(negedge clock);
            end
        end
    endtask

    // Fetch drops after losing twice; the counter must restart from zero.
    task automatic test_drop_fetch();
        logic fr   [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic expf [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic prev_f = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0007; f_addr = 16'h0009;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                checks++;
                if (f_rvalid !== prev_f) begin
                    errors++; $display("FAIL drop_resp[%0d]: got f_rvalid=%b want %b", k, f_rvalid, prev_f);
                end
            end
            if (k < 8) begin
                f_req = fr[k];
                #1;
                prev_f = expf[k];
                checks++;
                if (f_ready !== expf[k] || d_ready !== !expf[k]) begin
                    errors++; $display("FAIL drop_grant[%0d]: got f=%b d=%b want f=%b",
                                       k, f_ready, d_ready, expf[k]);
                end
            end else begin
                f_req = 1'b0; d_req = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_same_addr();
        f_req = 1'b1; f_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (d_ready !== 1'b1 || f_ready !== 1'b0) begin
            errors++; $display("FAIL same_first: got f=%b d=%b want 0 1", f_ready, d_ready);
        end
        @(negedge clock);
        d_req = 1'b0; d_we = 1'b0;
        #1;
        checks++;
        if (f_ready !== 1'b1) begin
            errors++; $display("FAIL same_second: got f_ready=%b want 1", f_ready);
        end
        @(negedge clock);
        checks++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'hCAFEF00D) begin
            errors++; $display("FAIL same_data: got v=%b d=%h want 1 cafef00d", f_rvalid, f_rdata);
        end
        f_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_out_of_range();
        // Last valid word
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h03FF;
        @(negedge clock);
        checks++;
        if (d_rvalid !== 1'b1 || d_fault !== 1'b0 || d_rdata !== pre(1023)) begin
            errors++; $display("FAIL edge_load: got v=%b f=%b d=%h want 1 0 %h",
                               d_rvalid, d_fault, d_rdata, pre(1023));
        end
        d_we = 1'b1; d_addr = 16'h0400; d_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (d_ready !== 1'b1 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL oor_cmd: got rdy=%b wren=%b want 1 0", d_ready, mem_wren);
        end
        @(negedge clock);
        checks++;
        if (d_rvalid !== 1'b1 || d_fault !== 1'b1 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL oor_resp: got v=%b f=%b d=%h want 1 1 0", d_rvalid, d_fault, d_rdata);
        end
        checks++;
        if (ram[0] !== pre(0)) begin
            errors++; $display("FAIL oor_ram0: got %h want %h", ram[0], pre(0));
        end
        d_req = 1'b0; d_we = 1'b0;
        f_req = 1'b1; f_addr = 16'hFFFF;
        #1;
        checks++;
        if (f_ready !== 1'b1 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL oor_fetch_cmd: got rdy=%b wren=%b want 1 0", f_ready, mem_wren);
        end
        @(negedge clock);
        checks++;
        if (f_rvalid !== 1'b1 || f_fault !== 1'b1 || f_rdata !== 32'h0 || d_fault !== 1'b0) begin
            errors++; $display("FAIL oor_fetch_resp: got v=%b f=%b d=%h df=%b want 1 1 0 0",
                               f_rvalid, f_fault, f_rdata, d_fault);
        end
        f_req = 1'b0;
        @(negedge clock);
        checks++;
        if (f_fault !== 1'b0 || f_rvalid !== 1'b0) begin
            errors++; $display("FAIL oor_pulse: got f=%b v=%b want 0 0", f_fault, f_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0003;
        @(posedge clock);
        #2;
        reset = 1'b1;
        d_we = 1'b1; d_wdata = 32'hBAD0_BAD0;
        @(negedge clock);
        checks++;
        if (d_rvalid !== 1'b0 || d_fault !== 1'b0 || d_rdata !== 32'h0 || f_rdata !== 32'h0) begin
            errors++; $display("FAIL midreset_resp: got v=%b f=%b d=%h fd=%h want 0 0 0 0",
                               d_rvalid, d_fault, d_rdata, f_rdata);
        end
        checks++;
        if (d_ready !== 1'b0 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL midreset_cmd: got rdy=%b wren=%b want 0 0", d_ready, mem_wren);
        end
        @(negedge clock);
        checks++;
        if (ram[3] !== pre(3)) begin
            errors++; $display("FAIL midreset_ram: got %h want %h", ram[3], pre(3));
        end
        d_req = 1'b0; d_we = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (d_rvalid !== 1'b0) begin
            errors++; $display("FAIL midreset_after: got d_rvalid=%b want 0", d_rvalid);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = pre(i);
        test_reset();
        test_store_load();
        test_fetch_stream();
        test_starvation();
        test_drop_fetch();
        test_same_addr();
        test_out_of_range();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
